// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster pixel-timing generator with delayed sync/DE copies
// Counters, decodes and strobes all advance only on i_en; decodes are registered from the next count.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int PIPE_DLY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_de,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_line_start,
  output logic        o_frame_start,
  output logic [15:0] o_frame_cnt,
  output logic        o_h_sync_dly,
  output logic        o_v_sync_dly,
  output logic        o_de_dly
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_SYNC == 0 || V_SYNC == 0 || H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_bad_zero
    $error("video_timing_gen: H_SYNC, V_SYNC, H_ACTIVE and V_ACTIVE must be non-zero");
  end
  if (H_TOTAL > 65535 || V_TOTAL > 65535) begin : g_bad_total
    $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 65535");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 8) begin : g_bad_dly
    $error("video_timing_gen: PIPE_DLY must be in 0..8");
  end

  localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic        H_ON   = 1'(H_POL);
  localparam logic        V_ON   = 1'(V_POL);

  logic [15:0] h_q, h_d, v_q, v_d, fc_q, fc_d;
  logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, ls_q, ls_d, fs_q, fs_d;

  always_comb begin
    h_d  = h_q;
    v_d  = v_q;
    fc_d = fc_q;
    de_d = de_q;
    hs_d = hs_q;
    vs_d = vs_q;
    ls_d = ls_q;
    fs_d = fs_q;
    if (i_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 16'd1;
      end else begin
        h_d = h_q + 16'd1;
      end
      // Decode the count being loaded so the outputs line up with o_x/o_y.
      de_d = (h_d < H_ACT) && (v_d < V_ACT);
      hs_d = (h_d >= HS_BEG && h_d <= HS_END) ? H_ON : ~H_ON;
      vs_d = (v_d >= VS_BEG && v_d <= VS_END) ? V_ON : ~V_ON;
      ls_d = (h_d == '0);
      fs_d = (h_d == '0) && (v_d == '0);
      if (fs_d) fc_d = fc_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q  <= H_LAST;
      v_q  <= V_LAST;
      fc_q <= '0;
      de_q <= 1'b0;
      hs_q <= ~H_ON;
      vs_q <= ~V_ON;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      fc_q <= fc_d;
      de_q <= de_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

  assign o_x           = h_q;
  assign o_y           = v_q;
  assign o_de          = de_q;
  assign o_h_sync      = hs_q;
  assign o_v_sync      = vs_q;
  assign o_line_start  = ls_q;
  assign o_frame_start = fs_q;
  assign o_frame_cnt   = fc_q;

  if (PIPE_DLY == 0) begin : g_no_dly
    assign o_de_dly     = de_q;
    assign o_h_sync_dly = hs_q;
    assign o_v_sync_dly = vs_q;
  end else begin : g_dly
    // Each stage holds {de, hsync, vsync}; stage PIPE_DLY-1 is the oldest.
    localparam logic [2:0] PIPE_RST = {1'b0, ~H_ON, ~V_ON};
    logic [2:0] pipe_q [PIPE_DLY];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < PIPE_DLY; i++) pipe_q[i] <= PIPE_RST;
      end else if (i_en) begin
        pipe_q[0] <= {de_q, hs_q, vs_q};
        for (int i = 1; i < PIPE_DLY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign o_de_dly     = pipe_q[PIPE_DLY-1][2];
    assign o_h_sync_dly = pipe_q[PIPE_DLY-1][1];
    assign o_v_sync_dly = pipe_q[PIPE_DLY-1][0];
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed bench for video_timing_gen
// Instance a uses the default 640x480 raster; instance b a 15x8 raster with PIPE_DLY = 3.
`timescale 1ns/1ps
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic en_a = 1'b0;
  logic en_b = 1'b0;

  logic [15:0] a_x, a_y, a_fc, b_x, b_y, b_fc;
  logic a_de, a_hs, a_vs, a_ls, a_fs, a_hsd, a_vsd, a_ded;
  logic b_de, b_hs, b_vs, b_ls, b_fs, b_hsd, b_vsd, b_ded;

  video_timing_gen u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_a),
    .o_x(a_x), .o_y(a_y), .o_de(a_de), .o_h_sync(a_hs), .o_v_sync(a_vs),
    .o_line_start(a_ls), .o_frame_start(a_fs), .o_frame_cnt(a_fc),
    .o_h_sync_dly(a_hsd), .o_v_sync_dly(a_vsd), .o_de_dly(a_ded)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(0), .V_POL(0), .PIPE_DLY(3)
  ) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en_b),
    .o_x(b_x), .o_y(b_y), .o_de(b_de), .o_h_sync(b_hs), .o_v_sync(b_vs),
    .o_line_start(b_ls), .o_frame_start(b_fs), .o_frame_cnt(b_fc),
    .o_h_sync_dly(b_hsd), .o_v_sync_dly(b_vsd), .o_de_dly(b_ded)
  );

  int vec = 0;
  int errs = 0;

  int mx, my, mfc;
  logic [2:0] hist[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 15x8 raster: active 0..7 / 0..3, hsync x 10..12, vsync y 5..6, both active-low.
  function automatic logic [2:0] b_dhv(input int x, input int y);
    return {(x < 8 && y < 4), !(x >= 10 && x <= 12), !(y >= 5 && y <= 6)};
  endfunction

  task automatic b_reset_model();
    mx = 14; my = 7; mfc = 0;
    hist = '{3'b011, 3'b011, 3'b011};
  endtask

  task automatic b_check(input string name);
    logic [2:0] e;
    e = b_dhv(mx, my);
    vec++;
    if ({b_x, b_y, b_de, b_hs, b_vs, b_ls, b_fs, b_fc, b_ded, b_hsd, b_vsd} !==
        {16'(mx), 16'(my), e, (mx == 0), (mx == 0 && my == 0), 16'(mfc), hist[0]}) begin
      errs++;
      $display("FAIL %s: got x=%0d y=%0d dhv=%b%b%b ls=%b fs=%b fc=%0d dly=%b%b%b, want x=%0d y=%0d dhv=%b ls=%b fs=%b fc=%0d dly=%b",
               name, b_x, b_y, b_de, b_hs, b_vs, b_ls, b_fs, b_fc, b_ded, b_hsd, b_vsd,
               mx, my, e, (mx == 0), (mx == 0 && my == 0), mfc, hist[0]);
    end
  endtask

  task automatic b_step(input logic en, input string name);
    en_b = en;
    tick();
    if (en) begin
      hist.push_back(b_dhv(mx, my));
      void'(hist.pop_front());
      if (mx == 14) begin
        mx = 0;
        my = (my == 7) ? 0 : my + 1;
      end else begin
        mx++;
      end
      if (mx == 0 && my == 0) mfc++;
    end
    b_check(name);
  endtask

  task automatic check_a_reset(input string name);
    vec++;
    if ({a_x, a_y, a_de, a_hs, a_vs, a_ls, a_fs, a_fc, a_ded, a_hsd, a_vsd} !==
        {16'd799, 16'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1}) begin
      errs++;
      $display("FAIL %s: got x=%0d y=%0d dhv=%b%b%b ls=%b fs=%b fc=%0d dly=%b%b%b, want x=799 y=524 dhv=011 ls=0 fs=0 fc=0 dly=011",
               name, a_x, a_y, a_de, a_hs, a_vs, a_ls, a_fs, a_fc, a_ded, a_hsd, a_vsd);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_a_reset("a_reset");
    b_reset_model();
    b_check("b_reset");
  endtask

  task automatic test_lines();
    logic [2:0] pe, ce;
    int ex, ey, nls;
    rst_n = 1'b1;
    en_a = 1'b1;
    pe = 3'b011;
    nls = 0;
    for (int c = 1; c <= 2400; c++) begin
      tick();
      ex = (c - 1) % 800;
      ey = (c - 1) / 800;
      ce = {(ex < 640), !(ex >= 656 && ex <= 751), 1'b1};
      if (a_ls) nls++;
      vec++;
      if ({a_x, a_y, a_de, a_hs, a_vs, a_ls, a_fs, a_fc, a_ded, a_hsd, a_vsd} !==
          {16'(ex), 16'(ey), ce, (ex == 0), (c == 1), 16'd1, pe}) begin
        errs++;
        $display("FAIL a_line c=%0d: got x=%0d y=%0d dhv=%b%b%b ls=%b fs=%b fc=%0d dly=%b%b%b, want x=%0d y=%0d dhv=%b ls=%b fs=%b fc=1 dly=%b",
                 c, a_x, a_y, a_de, a_hs, a_vs, a_ls, a_fs, a_fc, a_ded, a_hsd, a_vsd,
                 ex, ey, ce, (ex == 0), (c == 1), pe);
      end
      if (c == 641) begin
        vec++;
        if (a_x !== 16'd640 || a_de !== 1'b0) begin
          errs++;
          $display("FAIL a_de_edge: got x=%0d de=%b, want x=640 de=0", a_x, a_de);
        end
      end
      pe = ce;
    end
    vec++;
    if (nls != 3) begin
      errs++;
      $display("FAIL a_line_start_count: got %0d, want 3", nls);
    end
    en_a = 1'b0;
  endtask

  task automatic test_frames();
    int last_fs, nfs;
    last_fs = -1;
    nfs = 0;
    for (int n = 0; n < 250; n++) begin
      b_step(1'b1, "b_frame");
      if (b_fs) begin
        nfs++;
        if (last_fs >= 0) begin
          vec++;
          if (n - last_fs != 120) begin
            errs++;
            $display("FAIL b_frame_period: got %0d, want 120", n - last_fs);
          end
        end
        last_fs = n;
        if (nfs == 3) begin
          vec++;
          if (b_fc !== 16'd3) begin
            errs++;
            $display("FAIL b_frame_cnt3: got %0d, want 3", b_fc);
          end
        end
      end
    end
    vec++;
    if (nfs != 3) begin
      errs++;
      $display("FAIL b_frame_starts: got %0d, want 3", nfs);
    end
  endtask

  task automatic test_enable_gating();
    for (int n = 0; n < 400; n++) b_step(1'($urandom_range(0, 1)), "b_gated");
  endtask

  task automatic test_midframe_reset();
    int guard;
    guard = 0;
    while (!(mx == 5 && my == 2) && guard < 200) begin
      b_step(1'b1, "b_seek");
      guard++;
    end
    vec++;
    if (guard >= 200) begin
      errs++;
      $display("FAIL b_seek_timeout: got x=%0d y=%0d, want x=5 y=2", b_x, b_y);
    end
    rst_n = 1'b0;
    #1;
    b_reset_model();
    b_check("b_async_reset");
    check_a_reset("a_async_reset");
    en_b = 1'b1;
    tick();
    tick();
    b_check("b_reset_hold");
    rst_n = 1'b1;
    b_step(1'b1, "b_after_reset");
    vec++;
    if ({b_x, b_y, b_fc, b_ded, b_hsd, b_vsd} !== {16'd0, 16'd0, 16'd1, 3'b011}) begin
      errs++;
      $display("FAIL b_restart: got x=%0d y=%0d fc=%0d dly=%b%b%b, want x=0 y=0 fc=1 dly=011",
               b_x, b_y, b_fc, b_ded, b_hsd, b_vsd);
    end
    for (int n = 0; n < 20; n++) b_step(1'b1, "b_resume");
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lines();
    test_frames();
    test_enable_gating();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
